uart_rx_cfg: RTL and testbench

- Parametrised, runtime-configurable UART receiver; successor to the fixed 8N1 receiver.
- Adds:
  - configurable data width and oversampling ratio
  - runtime baud divisor, parity mode and stop-bit count
  - mid-bit majority sampling with start-glitch rejection
  - parity/framing/break/overrun detection
  - ready/valid output holding register
- Sits between the pad-side `rx` line and the host-side byte consumer (FIFO or register interface).

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_baud_tick.sv | 16 +
 rtl/uart_rx_cfg.sv | 125 ++++++++++++
 tb/tb_uart_rx_cfg.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and the three-sample majority vote
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10} parity_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2, BRKWAIT} rx_state_e;
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: prescaler emitting one oversample tick every baud_div+1 clocks
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             clear,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clear || cnt == baud_div) ? '0 : cnt + 1'b1;
  assign tick = !clear && cnt == baud_div;
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable oversampling UART receiver with ready/valid holding register
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OSR    = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop_bits,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              break_det,
  output logic              overrun,
  output logic              busy
);
  localparam int TW = $clog2(OSR);
  localparam int BW = $clog2(DATA_W + 1);
  rx_state_e state, state_n;
  logic s1, rxs, rxs_d, fall, tick, res, bit_v, done, fe_n, last_stop;
  logic [1:0] smp;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic [DATA_W-1:0] sh;
  logic [DIV_W-1:0] div_q;
  parity_e par_q;
  logic stop2_q, perr_q, ones_q;
  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk(clk), .rst_n(rst_n), .baud_div(div_q), .clear(state == IDLE), .tick(tick)
  );
  assign fall = rxs_d & ~rxs;
  assign res = tick && tcnt == TW'(OSR / 2 + 1);
  assign bit_v = maj3({smp, rxs});
  assign last_stop = !(state == STOP && stop2_q);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    done = 1'b0;
    fe_n = 1'b0;
    case (state)
      IDLE: state_n = fall ? START : IDLE;
      START: state_n = res ? (bit_v ? IDLE : DATA) : START;
      DATA: state_n = (res && bcnt == BW'(DATA_W - 1)) ? (par_q == PAR_NONE ? STOP : PARITY) : DATA;
      PARITY: state_n = res ? STOP : PARITY;
      STOP, STOP2: begin
        fe_n = res && !bit_v;
        done = res && (!bit_v || last_stop);
        state_n = !res ? state : !bit_v ? BRKWAIT : last_stop ? IDLE : STOP2;
      end
      BRKWAIT: state_n = rxs ? IDLE : BRKWAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b1;
      rxs <= 1'b1;
      rxs_d <= 1'b1;
      tcnt <= '0;
      bcnt <= '0;
      smp <= '0;
      sh <= '0;
      div_q <= '0;
      par_q <= PAR_NONE;
      stop2_q <= 1'b0;
      perr_q <= 1'b0;
      ones_q <= 1'b0;
    end else begin
      s1 <= rx;
      rxs <= s1;
      rxs_d <= rxs;
      if (state == IDLE) begin
        tcnt <= '0;
        bcnt <= '0;
        perr_q <= 1'b0;
        ones_q <= 1'b0;
        if (fall) begin
          div_q <= baud_div;
          par_q <= parity_mode == 2'b11 ? PAR_NONE : parity_e'(parity_mode);
          stop2_q <= stop_bits;
        end
      end else if (tick) begin
        tcnt <= tcnt == TW'(OSR - 1) ? '0 : tcnt + 1'b1;
        if (tcnt == TW'(OSR / 2 - 1)) smp[1] <= rxs;
        if (tcnt == TW'(OSR / 2)) smp[0] <= rxs;
        if (res && state == DATA) begin
          sh <= {bit_v, sh[DATA_W-1:1]};
          bcnt <= bcnt + 1'b1;
          ones_q <= ones_q | bit_v;
        end
        if (res && state == PARITY) begin
          perr_q <= (^{sh, bit_v}) != (par_q == PAR_ODD);
          ones_q <= ones_q | bit_v;
        end
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= done && rx_valid && !rx_ready;
      if (done && (!rx_valid || rx_ready)) begin
        rx_data <= sh;
        rx_valid <= 1'b1;
        parity_err <= perr_q;
        frame_err <= fe_n;
        break_det <= fe_n & ~ones_q;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: table-driven and directed checks of uart_rx_cfg at 64 clk per bit
module tb_uart_rx_cfg;
  logic clk = 1'b0, rst_n, rx, rx_ready, stop_bits;
  logic [15:0] baud_div;
  logic [1:0] parity_mode;
  logic [7:0] rx_data;
  logic rx_valid, parity_err, frame_err, break_det, overrun, busy;
  int n_cmp = 0, n_bad = 0;
  int cap_n = 0, vcyc = 0, ovr_n = 0;
  logic [7:0] cap_d;
  logic cap_pe, cap_fe, cap_bk;
  int c0, v0, o0;
  typedef struct {
    logic [1:0] pm;
    logic two;
    logic [7:0] d;
    logic pb;
    logic sb;
    logic [7:0] ed;
    logic epe;
    logic efe;
    logic ebk;
  } vec_t;
  vec_t tbl[9];
  uart_rx_cfg dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop_bits(stop_bits), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .break_det(break_det), .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      cap_n++;
      cap_d = rx_data;
      cap_pe = parity_err;
      cap_fe = frame_err;
      cap_bk = break_det;
    end
    if (rx_valid) vcyc++;
    if (overrun) ovr_n++;
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic hp, input logic pb, input logic sb, input logic two);
    rx = 1'b0;
    cyc(64);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(64);
    end
    if (hp) begin
      rx = pb;
      cyc(64);
    end
    rx = sb;
    cyc(64);
    if (two && sb) cyc(64);
    rx = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b1;
    baud_div = 16'd3;
    parity_mode = 2'b00;
    stop_bits = 1'b0;
    cyc(3);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rx_data", rx_data, 0);
    chk("reset flags", {parity_err, frame_err, break_det, overrun}, 0);
    chk("reset busy", busy, 0);
    rst_n = 1'b1;
    cyc(5);
    tbl[0] = '{2'b00, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'b01, 1'b0, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{2'b10, 1'b0, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{2'b01, 1'b0, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{2'b00, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{2'b00, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{2'b11, 1'b0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{2'b10, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 9; k++) begin
      parity_mode = tbl[k].pm;
      stop_bits = tbl[k].two;
      c0 = cap_n;
      v0 = vcyc;
      send(tbl[k].d, tbl[k].pm == 2'b01 || tbl[k].pm == 2'b10, tbl[k].pb, tbl[k].sb, tbl[k].two);
      cyc(128);
      chk($sformatf("vec%0d words", k), cap_n - c0, 1);
      chk($sformatf("vec%0d valid cycles", k), vcyc - v0, 1);
      chk($sformatf("vec%0d data", k), cap_d, tbl[k].ed);
      chk($sformatf("vec%0d parity_err", k), cap_pe, tbl[k].epe);
      chk($sformatf("vec%0d frame_err", k), cap_fe, tbl[k].efe);
      chk($sformatf("vec%0d break_det", k), cap_bk, tbl[k].ebk);
      chk($sformatf("vec%0d busy", k), busy, 0);
    end
    parity_mode = 2'b00;
    stop_bits = 1'b0;
    c0 = cap_n;
    rx = 1'b0;
    cyc(64);
    for (int i = 0; i < 8; i++) begin
      rx = i[0] ? 1'b1 : 1'b0;
      cyc(64);
    end
    rx = 1'b0;
    cyc(164);
    chk("stop0 words", cap_n - c0, 1);
    chk("stop0 data", cap_d, 8'hAA);
    chk("stop0 frame_err", cap_fe, 1);
    chk("stop0 break_det", cap_bk, 0);
    chk("stop0 busy held", busy, 1);
    rx = 1'b1;
    cyc(6);
    chk("stop0 busy release", busy, 0);
    c0 = cap_n;
    rx = 1'b0;
    cyc(768);
    chk("break words", cap_n - c0, 1);
    chk("break data", cap_d, 0);
    chk("break frame_err", cap_fe, 1);
    chk("break break_det", cap_bk, 1);
    chk("break busy in brkwait", busy, 1);
    rx = 1'b1;
    cyc(6);
    chk("break busy release", busy, 0);
    cyc(64);
    c0 = cap_n;
    rx = 1'b0;
    cyc(8);
    chk("glitch busy rise", busy, 1);
    cyc(8);
    rx = 1'b1;
    cyc(192);
    chk("glitch words", cap_n - c0, 0);
    chk("glitch busy", busy, 0);
    rx_ready = 1'b0;
    c0 = cap_n;
    o0 = ovr_n;
    send(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(64);
    send(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(128);
    chk("overrun pulses", ovr_n - o0, 1);
    chk("overrun held valid", rx_valid, 1);
    chk("overrun held data", rx_data, 8'h11);
    chk("overrun no accept", cap_n - c0, 0);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    chk("drain words", cap_n - c0, 1);
    chk("drain data", cap_d, 8'h11);
    cyc(2);
    chk("drain valid low", rx_valid, 0);
    rx_ready = 1'b1;
    rx = 1'b0;
    cyc(64);
    rx = 1'b1;
    cyc(192);
    chk("mid busy", busy, 1);
    rst_n = 1'b0;
    cyc(2);
    chk("midrst rx_data", rx_data, 0);
    chk("midrst rx_valid", rx_valid, 0);
    chk("midrst flags", {parity_err, frame_err, break_det, overrun}, 0);
    chk("midrst busy", busy, 0);
    rst_n = 1'b1;
    cyc(64);
    c0 = cap_n;
    send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(128);
    chk("post-reset words", cap_n - c0, 1);
    chk("post-reset data", cap_d, 8'h3C);
    chk("post-reset flags", {cap_pe, cap_fe, cap_bk}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
